raster_mem_sched: RTL and testbench
===================================

Name: raster_mem_sched

Overview:
Controller and output arbiter for a group of NUM_UNITS raster memory-fetch units that share one rasterizer slice.
- Broadcasts a launch pulse to the enabled units and tracks their completion.
- Merges their primitive streams (pid, tile xloc/yloc, 3x3 edge words) into one registered output stream using burst-limited round-robin arbitration.
- Reports a single busy/done status back to the raster top level.

Parameters:
NUM_UNITS, 4, number of fetch units arbitrated (1..16)
PID_BITS, 16, primitive id width
DIM_BITS, 16, tile coordinate width
DATA_BITS, 32, edge coefficient word width
MAX_BURST, 8, max consecutive grants to one unit before rotation (power of two, >=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  launch pulse from DCR logic
unit_mask  in  NUM_UNITS  enabled units; sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
prim_count  out  32  primitives output in current/last run, saturating
unit_start  out  NUM_UNITS  one-cycle start pulse per enabled unit
unit_busy  in  NUM_UNITS  per-unit busy
unit_valid  in  NUM_UNITS  per-unit output valid
unit_pid  in  NUM_UNITS*PID_BITS  per-unit primitive id
unit_xloc  in  NUM_UNITS*DIM_BITS  per-unit tile x
unit_yloc  in  NUM_UNITS*DIM_BITS  per-unit tile y
unit_edges  in  NUM_UNITS*9*DATA_BITS  per-unit edge words
unit_ready  out  NUM_UNITS  per-unit ready
valid_out  out  1  merged output valid
pid_out  out  PID_BITS
xloc_out  out  DIM_BITS
yloc_out  out  DIM_BITS
edges_out  out  9*DATA_BITS
ready_out  in  1  downstream ready

Behaviour:
- Reset values: busy=0, done=0, unit_start=0, valid_out=0, prim_count=0, unit_ready=0. FSM=IDLE, round-robin pointer=0, burst counter=0. Reset mid-run drops any held output beat; units are reset by the same reset.
- FSM states: IDLE, LAUNCH, RUN, DONE.
  - IDLE: start=1 with unit_mask!=0 -> unit_start=unit_mask for exactly one cycle (registered), mask latched, prim_count cleared, go to LAUNCH. start with unit_mask==0 -> done pulse next cycle, busy stays 0. start in any non-IDLE state is ignored.
  - LAUNCH: one cycle, covers the units' registered busy. Then RUN.
  - RUN: exit when, in the same cycle, all of the following hold: (unit_busy & mask)==0, (unit_valid & mask)==0, valid_out==0. Then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - busy=1 in LAUNCH, RUN and DONE.
- Output stage: single register with ready pass-through.
  - Beat transfers on valid_out && ready_out.
  - Register loads when empty or being drained in the same cycle (load_en = ~valid_out || ready_out).
- Arbitration:
  - Candidates are unit_valid & latched mask.
  - Grant is one-hot, computed combinationally from a registered pointer.
  - unit_ready[i] = grant[i] && load_en. A unit fires on unit_valid[i] && unit_ready[i].
  - Lock: after the current owner fires, it keeps priority while it stays valid and burst counter < MAX_BURST-1.
  - Rotation: on the MAX_BURST-th consecutive fire, or when the owner is not valid, the pointer moves to the next valid unit after the owner, cyclically, and the burst counter clears. A single requester may be re-granted immediately after rotation.
  - Non-granted units are never acknowledged. Unmasked units are never granted.
- Latency: unit fire -> valid_out next cycle. Full throughput: 1 beat/cycle while ready_out=1.
- prim_count increments on each output transfer and saturates at 2^32-1.
- Input payload is captured only on fire. Output fields hold stable while valid_out && ~ready_out.

Decomposition:
- VX_raster_pkg gains raster_prim_t (pid, xloc, yloc, edges[3][3]) and RASTER_SCHED_FSM state encodings.
- One sub-module, raster_rr_arbiter: burst-locked round-robin grant with pointer and burst counter.
- The FSM, output register and counter stay in the top.

Test Plan:
- Single unit, mask=4'b0001, 5 beats, ready_out=1 -> 5 outputs in order, 1 cycle latency, prim_count=5, done pulse once, busy high start..done.
- Units 0 and 2 always valid, MAX_BURST=8, 20 beats each -> output order 8xU0, 8xU2, 8xU0, 8xU2, 4xU0, 4xU2. No other unit_ready ever asserts.
- Backpressure: ready_out toggles 1/0 each cycle -> no beat lost or duplicated; output payload holds stable while stalled; unit_ready=0 on stall cycles.
- start while busy (RUN) -> ignored, no extra unit_start; start with unit_mask=0 -> done one cycle later, busy never rises.
- Completion ordering: unit_busy falls while the last beat sits in the output register with ready_out=0 -> done only after that beat transfers.
- Reset asserted mid-run with valid_out=1 -> next cycle valid_out=0, busy=0, prim_count=0, FSM IDLE; a new start works normally.

Source files
------------

// File: rtl/raster_mem_sched_pkg.sv
// Shared types, state encodings and helpers for the raster memory-fetch scheduler.
package raster_mem_sched_pkg;

  localparam int RASTER_PID_BITS   = 16;
  localparam int RASTER_DIM_BITS   = 16;
  localparam int RASTER_DATA_BITS  = 32;
  localparam int RASTER_EDGE_WORDS = 9;

  // One primitive beat as it travels from a fetch unit to the rasterizer slice.
  typedef struct packed {
    logic [RASTER_PID_BITS-1:0]             pid;
    logic [RASTER_DIM_BITS-1:0]             xloc;
    logic [RASTER_DIM_BITS-1:0]             yloc;
    logic [2:0][2:0][RASTER_DATA_BITS-1:0]  edges;
  } raster_prim_t;

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_LAUNCH = 2'd1,
    SCHED_RUN    = 2'd2,
    SCHED_DONE   = 2'd3
  } sched_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/raster_mem_sched_rr_arbiter.sv
// Burst-locked round-robin arbiter: the owner keeps priority for up to MAX_BURST
// consecutive fires, then priority moves to the next requester after it.
module raster_mem_sched_rr_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int MAX_BURST = 8,
  localparam int PTR_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int BURST_W = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] cand,
  input  logic                 fire,
  output logic [NUM_UNITS-1:0] grant,
  output logic [PTR_W-1:0]     grant_idx
);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   next_idx;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] run_len;

  // Scan from the pointer downwards so the closest requester at or after ptr wins last.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      scan_idx = PTR_W'((int'(ptr) + k) % NUM_UNITS);
      if (cand[scan_idx]) begin
        grant           = '0;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  // A grant to anyone other than the owner starts a fresh run for the new owner.
  assign run_len  = (grant_idx == ptr) ? burst + 1'b1 : BURST_W'(1);
  assign next_idx = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      burst <= '0;
    end else if (fire) begin
      if (run_len == BURST_W'(MAX_BURST)) begin
        ptr   <= next_idx;
        burst <= '0;
      end else begin
        ptr   <= grant_idx;
        burst <= run_len;
      end
    end else if (!cand[ptr]) begin
      burst <= '0;
    end
  end

endmodule

// File: rtl/raster_mem_sched.sv
// Launch/completion controller and merged output stage for a group of raster
// memory-fetch units sharing one rasterizer slice.
module raster_mem_sched
  import raster_mem_sched_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int PID_BITS  = 16,
  parameter int DIM_BITS  = 16,
  parameter int DATA_BITS = 32,
  parameter int MAX_BURST = 8,
  localparam int EDGE_BITS = RASTER_EDGE_WORDS * DATA_BITS,
  localparam int PTR_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_UNITS-1:0]           unit_mask,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    prim_count,
  output logic [NUM_UNITS-1:0]           unit_start,
  input  logic [NUM_UNITS-1:0]           unit_busy,
  input  logic [NUM_UNITS-1:0]           unit_valid,
  input  logic [NUM_UNITS*PID_BITS-1:0]  unit_pid,
  input  logic [NUM_UNITS*DIM_BITS-1:0]  unit_xloc,
  input  logic [NUM_UNITS*DIM_BITS-1:0]  unit_yloc,
  input  logic [NUM_UNITS*EDGE_BITS-1:0] unit_edges,
  output logic [NUM_UNITS-1:0]           unit_ready,
  output logic                           valid_out,
  output logic [PID_BITS-1:0]            pid_out,
  output logic [DIM_BITS-1:0]            xloc_out,
  output logic [DIM_BITS-1:0]            yloc_out,
  output logic [EDGE_BITS-1:0]           edges_out,
  input  logic                           ready_out
);

  sched_state_e         state;
  logic [NUM_UNITS-1:0] mask_q;
  logic [NUM_UNITS-1:0] cand;
  logic [NUM_UNITS-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 load_en;
  logic                 fire;
  logic                 xfer;
  logic                 run_exit;

  assign load_en = ~valid_out | ready_out;
  assign xfer    = valid_out & ready_out;
  assign cand    = (state == SCHED_RUN && !reset) ? (unit_valid & mask_q) : '0;

  // grant is a subset of cand, so any grant bit means the granted unit is valid.
  assign fire       = (|grant) & load_en;
  assign unit_ready = grant & {NUM_UNITS{load_en}};

  // The run is over only when no enabled unit is working, offering, or parked in the output register.
  assign run_exit = (((unit_busy | unit_valid) & mask_q) == '0) && !valid_out;

  raster_mem_sched_rr_arbiter #(
    .NUM_UNITS (NUM_UNITS),
    .MAX_BURST (MAX_BURST)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .cand      (cand),
    .fire      (fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCHED_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      unit_start <= '0;
      mask_q     <= '0;
      prim_count <= '0;
    end else begin
      done       <= 1'b0;
      unit_start <= '0;
      if (xfer) prim_count <= sat_inc32(prim_count);
      case (state)
        SCHED_IDLE: begin
          if (start) begin
            if (unit_mask != '0) begin
              state      <= SCHED_LAUNCH;
              busy       <= 1'b1;
              unit_start <= unit_mask;
              mask_q     <= unit_mask;
              prim_count <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        // One cycle of slack so the units' registered busy is visible before RUN checks it.
        SCHED_LAUNCH: state <= SCHED_RUN;
        SCHED_RUN: begin
          if (run_exit) begin
            state <= SCHED_DONE;
            done  <= 1'b1;
          end
        end
        SCHED_DONE: begin
          state <= SCHED_IDLE;
          busy  <= 1'b0;
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_out <= 1'b0;
    else if (load_en) valid_out <= fire;
  end

  // NOTE: payload registers carry no reset; valid_out alone qualifies them.
  always_ff @(posedge clk) begin
    if (fire) begin
      pid_out   <= unit_pid[grant_idx*PID_BITS +: PID_BITS];
      xloc_out  <= unit_xloc[grant_idx*DIM_BITS +: DIM_BITS];
      yloc_out  <= unit_yloc[grant_idx*DIM_BITS +: DIM_BITS];
      edges_out <= unit_edges[grant_idx*EDGE_BITS +: EDGE_BITS];
    end
  end

endmodule

// File: tb/tb_raster_mem_sched.sv
// Randomized self-checking bench: fetch units are queues of primitives and the
// expected merged stream is derived by taking turns of up to MAX_BURST beats per unit.
module tb_raster_mem_sched;
  import raster_mem_sched_pkg::*;

  localparam int NUM_UNITS = 4;
  localparam int PID_BITS  = RASTER_PID_BITS;
  localparam int DIM_BITS  = RASTER_DIM_BITS;
  localparam int DATA_BITS = RASTER_DATA_BITS;
  localparam int MAX_BURST = 8;
  localparam int EDGE_BITS = RASTER_EDGE_WORDS * DATA_BITS;

  logic                           clk;
  logic                           reset;
  logic                           start;
  logic [NUM_UNITS-1:0]           unit_mask;
  logic                           busy;
  logic                           done;
  logic [31:0]                    prim_count;
  logic [NUM_UNITS-1:0]           unit_start;
  logic [NUM_UNITS-1:0]           unit_busy;
  logic [NUM_UNITS-1:0]           unit_valid;
  logic [NUM_UNITS*PID_BITS-1:0]  unit_pid;
  logic [NUM_UNITS*DIM_BITS-1:0]  unit_xloc;
  logic [NUM_UNITS*DIM_BITS-1:0]  unit_yloc;
  logic [NUM_UNITS*EDGE_BITS-1:0] unit_edges;
  logic [NUM_UNITS-1:0]           unit_ready;
  logic                           valid_out;
  logic [PID_BITS-1:0]            pid_out;
  logic [DIM_BITS-1:0]            xloc_out;
  logic [DIM_BITS-1:0]            yloc_out;
  logic [EDGE_BITS-1:0]           edges_out;
  logic                           ready_out;

  raster_mem_sched #(
    .NUM_UNITS (NUM_UNITS),
    .PID_BITS  (PID_BITS),
    .DIM_BITS  (DIM_BITS),
    .DATA_BITS (DATA_BITS),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .unit_mask  (unit_mask),
    .busy       (busy),
    .done       (done),
    .prim_count (prim_count),
    .unit_start (unit_start),
    .unit_busy  (unit_busy),
    .unit_valid (unit_valid),
    .unit_pid   (unit_pid),
    .unit_xloc  (unit_xloc),
    .unit_yloc  (unit_yloc),
    .unit_edges (unit_edges),
    .unit_ready (unit_ready),
    .valid_out  (valid_out),
    .pid_out    (pid_out),
    .xloc_out   (xloc_out),
    .yloc_out   (yloc_out),
    .edges_out  (edges_out),
    .ready_out  (ready_out)
  );

  always #5 clk = ~clk;

  // Unit models and scoreboard
  raster_prim_t         uq [NUM_UNITS][$];
  int                   tail [NUM_UNITS];
  logic [NUM_UNITS-1:0] launched;
  logic [NUM_UNITS-1:0] run_mask;
  raster_prim_t         exp_q[$];
  int                   out_src[$];

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt;
  int ustart_cnt;
  int ready_mode;      // 0 always ready, 1 toggle, 2 random, 3 held low
  bit chk_latency;
  bit exp_busy;
  bit rst_seen;
  bit prev_stall;
  bit prev_fire;
  raster_prim_t prev_got;

  logic                 s_valid, s_busy, s_done;
  logic [31:0]          s_prim;
  logic [NUM_UNITS-1:0] s_ustart, s_uready;

  task automatic drive_units();
    raster_prim_t p;
    for (int i = 0; i < NUM_UNITS; i++) begin
      p = '0;
      if (uq[i].size() > 0) p = uq[i][0];
      unit_valid[i] = (uq[i].size() > 0) && (launched[i] || !run_mask[i]);
      unit_busy[i]  = launched[i] && (uq[i].size() > 0 || tail[i] > 0);
      unit_pid[i*PID_BITS +: PID_BITS]     = p.pid;
      unit_xloc[i*DIM_BITS +: DIM_BITS]    = p.xloc;
      unit_yloc[i*DIM_BITS +: DIM_BITS]    = p.yloc;
      unit_edges[i*EDGE_BITS +: EDGE_BITS] = p.edges;
    end
  endtask

  // One clock: observe and check at the falling edge, advance the unit models after the rising edge.
  task automatic step();
    logic [NUM_UNITS-1:0] fire_s, ustart_s;
    logic                 acc, done_now;
    raster_prim_t         got;
    @(negedge clk);
    s_valid = valid_out; s_busy = busy; s_done = done; s_prim = prim_count;
    s_ustart = unit_start; s_uready = unit_ready;
    got = {pid_out, xloc_out, yloc_out, edges_out};
    fire_s = unit_valid & unit_ready;
    done_now = done;
    if (rst_seen) begin
      n_checks++;
      if (((unit_ready & ~run_mask) != '0) || ($countones(unit_ready) > 1))
        begin n_err++; $display("FAIL ready_grant: unit_ready=%b mask=%b", unit_ready, run_mask); end
      n_checks++;
      if (busy !== exp_busy) begin n_err++; $display("FAIL busy: got %b want %b", busy, exp_busy); end
      if (prev_stall) begin
        n_checks++;
        if (got !== prev_got || valid_out !== 1'b1)
          begin n_err++; $display("FAIL hold: pid %h want %h valid %b", got.pid, prev_got.pid, valid_out); end
      end
      if (valid_out === 1'b1 && ready_out === 1'b0) begin
        n_checks++;
        if (unit_ready !== '0) begin n_err++; $display("FAIL stall_ready: unit_ready=%b want 0", unit_ready); end
      end
      if (valid_out === 1'b1 && ready_out === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL extra_beat: pid %h with none expected", got.pid); end
        else begin
          if (got !== exp_q[0])
            begin n_err++; $display("FAIL beat: pid %h x %h got, pid %h x %h want", got.pid, got.xloc, exp_q[0].pid, exp_q[0].xloc); end
          void'(exp_q.pop_front());
        end
        out_src.push_back(int'(got.pid[PID_BITS-1 -: 4]));
      end
      if (chk_latency) begin
        n_checks++;
        if (valid_out !== prev_fire) begin n_err++; $display("FAIL latency: valid_out %b want %b", valid_out, prev_fire); end
      end
      if (done === 1'b1) begin
        done_cnt++;
        n_checks++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL done_early: %0d beats outstanding want 0", exp_q.size()); end
      end
      if (unit_start != '0) ustart_cnt++;
    end
    prev_stall = (valid_out === 1'b1) && (ready_out === 1'b0);
    prev_got   = got;
    prev_fire  = |fire_s;
    ustart_s   = unit_start;
    acc        = start && !exp_busy && (unit_mask != '0);
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin uq[i].delete(); tail[i] = 0; end
      launched = '0; exp_q.delete();
      exp_busy = 1'b0; prev_stall = 1'b0; prev_fire = 1'b0; rst_seen = 1'b1;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (fire_s[i] && uq[i].size() > 0) void'(uq[i].pop_front());
        if (ustart_s[i]) launched[i] = 1'b1;
        else if (launched[i] && uq[i].size() == 0 && tail[i] > 0) tail[i]--;
      end
      if (done_now === 1'b1) begin exp_busy = 1'b0; launched = '0; end
      if (acc) exp_busy = 1'b1;
    end
    case (ready_mode)
      0: ready_out = 1'b1;
      1: ready_out = ~ready_out;
      2: ready_out = 1'($urandom_range(0, 1));
      default: ready_out = 1'b0;
    endcase
    drive_units();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Fill unit queues; unmasked units optionally carry data they must never get to send.
  task automatic load_units(input logic [NUM_UNITS-1:0] m, input int lo, input int hi,
                            input bit rogue, input int tail_max);
    raster_prim_t p;
    int n;
    for (int i = 0; i < NUM_UNITS; i++) begin
      uq[i].delete();
      n = m[i] ? int'($urandom_range(hi, lo)) : (rogue ? 3 : 0);
      for (int k = 0; k < n; k++) begin
        p.pid  = {4'(i), 12'(k)};
        p.xloc = 16'($urandom);
        p.yloc = 16'($urandom);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) p.edges[r][c] = $urandom;
        uq[i].push_back(p);
      end
      tail[i] = int'($urandom_range(tail_max, 0));
    end
  endtask

  // Reference order: units take turns in index order, each turn up to MAX_BURST beats.
  function automatic void build_expected(input logic [NUM_UNITS-1:0] m);
    int rem[NUM_UNITS];
    int pos[NUM_UNITS];
    int left = 0;
    int u = 0;
    exp_q.delete();
    for (int i = 0; i < NUM_UNITS; i++) begin
      rem[i] = m[i] ? uq[i].size() : 0;
      pos[i] = 0;
      left += rem[i];
    end
    while (left > 0) begin
      for (int b = 0; b < MAX_BURST && rem[u] > 0; b++) begin
        exp_q.push_back(uq[u][pos[u]]);
        pos[u]++; rem[u]--; left--;
      end
      u = (u + 1) % NUM_UNITS;
    end
  endfunction

  task automatic start_run(input logic [NUM_UNITS-1:0] m, output int total);
    run_mask = m;
    build_expected(m);
    total = exp_q.size();
    done_cnt = 0; ustart_cnt = 0; out_src.delete();
    drive_units();
    unit_mask = m; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (s_ustart !== m) begin n_err++; $display("FAIL unit_start: got %b want %b", s_ustart, m); end
  endtask

  task automatic run_to_done(input int budget, input int total);
    int n = 0;
    while (s_done !== 1'b1 && n < budget) begin step(); n++; end
    n_checks++;
    if (s_done !== 1'b1) begin n_err++; $display("FAIL timeout: no done within %0d cycles", budget); end
    else begin
      n_checks++;
      if (s_prim !== 32'(total)) begin n_err++; $display("FAIL prim_count: got %0d want %0d", s_prim, total); end
    end
    step();
    n_checks++;
    if (s_done !== 1'b0 || s_busy !== 1'b0)
      begin n_err++; $display("FAIL done_pulse: done %b busy %b want 0 0", s_done, s_busy); end
    n_checks++;
    if (done_cnt != 1 || ustart_cnt != 1)
      begin n_err++; $display("FAIL pulses: done x%0d unit_start x%0d want 1 1", done_cnt, ustart_cnt); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", s_busy); end
    n_checks++; if (s_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", s_done); end
    n_checks++; if (s_ustart !== '0) begin n_err++; $display("FAIL rst_unit_start: got %b want 0", s_ustart); end
    n_checks++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", s_valid); end
    n_checks++; if (s_prim !== '0) begin n_err++; $display("FAIL rst_prim: got %0d want 0", s_prim); end
    n_checks++; if (s_uready !== '0) begin n_err++; $display("FAIL rst_ready: got %b want 0", s_uready); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int total;
    do_reset();
    ready_mode = 0;
    step();
    load_units(4'b0001, 5, 5, 1'b0, 0);
    chk_latency = 1'b1;
    start_run(4'b0001, total);
    run_to_done(100, total);
    chk_latency = 1'b0;
  endtask

  task automatic test_two_units();
    int total;
    int ru[$];
    int rn[$];
    int exp_u[6] = '{0, 2, 0, 2, 0, 2};
    int exp_n[6] = '{8, 8, 8, 8, 4, 4};
    do_reset();
    ready_mode = 0;
    step();
    load_units(4'b0101, 20, 20, 1'b1, 0);
    start_run(4'b0101, total);
    run_to_done(200, total);
    foreach (out_src[k]) begin
      if (ru.size() > 0 && ru[ru.size()-1] == out_src[k]) rn[rn.size()-1]++;
      else begin ru.push_back(out_src[k]); rn.push_back(1); end
    end
    n_checks++;
    if (ru.size() != 6) begin n_err++; $display("FAIL burst_runs: got %0d runs want 6", ru.size()); end
    for (int k = 0; k < 6 && k < ru.size(); k++) begin
      n_checks++;
      if (ru[k] != exp_u[k] || rn[k] != exp_n[k])
        begin n_err++; $display("FAIL burst_run%0d: U%0d x%0d want U%0d x%0d", k, ru[k], rn[k], exp_u[k], exp_n[k]); end
    end
  endtask

  task automatic test_backpressure();
    int total;
    logic [NUM_UNITS-1:0] m;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ready_mode = (r < 3) ? 1 : 2;
      m = NUM_UNITS'($urandom_range(15, 1));
      load_units(m, 0, 12, 1'b1, 3);
      start_run(m, total);
      run_to_done(2000, total);
    end
  endtask

  task automatic test_start_while_busy();
    int total;
    do_reset();
    ready_mode = 1;
    load_units(4'b0011, 6, 6, 1'b0, 0);
    start_run(4'b0011, total);
    step(); step();
    unit_mask = 4'b1100; start = 1'b1;
    step();
    start = 1'b0;
    run_to_done(200, total);
    unit_mask = '0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (s_done !== 1'b1) begin n_err++; $display("FAIL zero_mask_done: got %b want 1", s_done); end
    step();
    n_checks++;
    if (s_done !== 1'b0 || s_ustart !== '0)
      begin n_err++; $display("FAIL zero_mask_after: done %b unit_start %b want 0 0", s_done, s_ustart); end
  endtask

  task automatic test_completion_order();
    int total;
    do_reset();
    ready_mode = 3;
    step();
    load_units(4'b0001, 1, 1, 1'b0, 0);
    start_run(4'b0001, total);
    for (int k = 0; k < 8; k++) step();
    n_checks++;
    if (s_valid !== 1'b1 || done_cnt != 0)
      begin n_err++; $display("FAIL parked_beat: valid %b done x%0d want 1 0", s_valid, done_cnt); end
    ready_mode = 0;
    run_to_done(50, total);
  endtask

  task automatic test_reset_mid_run();
    int total;
    int n = 0;
    do_reset();
    ready_mode = 0;
    step();
    load_units(4'b1111, 10, 10, 1'b0, 0);
    start_run(4'b1111, total);
    for (int k = 0; k < 5; k++) step();
    ready_mode = 3;
    step();
    while (s_valid !== 1'b1 && n < 20) begin step(); n++; end
    n_checks++;
    if (s_valid !== 1'b1 || s_prim == '0)
      begin n_err++; $display("FAIL pre_reset: valid %b prim %0d want 1 and nonzero", s_valid, s_prim); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_prim !== '0)
      begin n_err++; $display("FAIL mid_reset: valid %b busy %b prim %0d want 0 0 0", s_valid, s_busy, s_prim); end
    ready_mode = 0;
    step();
    load_units(4'b0010, 4, 4, 1'b0, 0);
    start_run(4'b0010, total);
    run_to_done(100, total);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; start = 1'b0; unit_mask = '0; ready_out = 1'b0;
    ready_mode = 0; chk_latency = 1'b0; exp_busy = 1'b0; rst_seen = 1'b0;
    prev_stall = 1'b0; prev_fire = 1'b0; prev_got = '0;
    launched = '0; run_mask = '0; done_cnt = 0; ustart_cnt = 0;
    for (int i = 0; i < NUM_UNITS; i++) tail[i] = 0;
    drive_units();
    test_reset();
    test_single();
    test_two_units();
    test_backpressure();
    test_start_while_busy();
    test_completion_order();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
